// File: rtl/spart_rx_param.sv
//-----------------------------------------------------------------------------
// spart_rx_param
// SPART receiver. rxd is synchronised, oversampled 16x per bit, and each bit
// is the majority of the samples at ticks 7, 8 and 9. Frames carry DATA_BITS
// data bits LSB first, an optional parity bit (mode latched at start) and one
// stop bit. Each frame lands in a show-ahead receive FIFO as
// {break, frame, parity, data}.
//
// Optional feature (macro SPART_RX_BREAK_EN): an all-zero frame with a zero
// stop bit is flagged as a line break. After a break the receiver waits for
// the line to be high for a full oversample tick before it re-arms.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   rxd       asynchronous serial input, idle high
//   divisor   clocks per oversample tick (0 holds the receiver idle)
//   par_mode  00 none, 01 even, 10 odd, 11 none
//   rd_en     pop FIFO head
//   ovr_clr   clear sticky overrun flag
//   rd_data   FIFO head data (show-ahead), 0 when empty
//   rd_err    FIFO head flags {break, frame, parity}, 0 when empty
//   rda       FIFO non-empty
//   fifo_cnt  entries held
//   overrun   sticky: a frame was dropped because the FIFO was full
//-----------------------------------------------------------------------------
module spart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rxd,
   input  logic [DIV_W-1:0]             divisor,
   input  logic [1:0]                   par_mode,
   input  logic                         rd_en,
   input  logic                         ovr_clr,
   output logic [DATA_BITS-1:0]         rd_data,
   output logic [2:0]                   rd_err,
   output logic                         rda,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
   output logic                         overrun
);

   localparam int               AW       = $clog2(FIFO_DEPTH);
   localparam int               EW       = DATA_BITS + 3;
   localparam logic [3:0]       LAST_BIT = DATA_BITS[3:0];
   localparam logic [AW:0]      CNT_FULL = FIFO_DEPTH[AW:0];
   localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY   = 3'd3,
      STOP     = 3'd4
`ifdef SPART_RX_BREAK_EN
      , BRK_WAIT = 3'd5
`endif
   } state_t;

   // Parity error flag: received data XOR parity bit must be 0 (even) or 1 (odd).
   function automatic logic par_err_f(input logic [DATA_BITS-1:0] d,
                                      input logic                 rbit,
                                      input logic                 odd);
      return (^d) ^ rbit ^ odd;
   endfunction

   state_t               state_r, state_nxt_s;
   logic                 sync1_r, rxs_r, rxs_prev_r;
   logic [DIV_W-1:0]     tcnt_r;
   logic [3:0]           tick_idx_r;
   logic [1:0]           samp_r;
   logic [3:0]           bit_cnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 par_en_r, par_odd_r, par_err_r;
   logic                 push_req_r;
   logic [EW-1:0]        push_entry_r;
   logic                 tick_s, at9_s, end_s, maj_s;
   logic                 start_s, shift_en_s, par_smp_s, push_s;
   logic [EW-1:0]        entry_s;
`ifdef SPART_RX_BREAK_EN
   logic                 par_bit_r, hi_seen_r, brk_s;
`endif

   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
   logic [AW:0]          fcnt_r, fcnt_nxt_s;
   logic                 pop_s, full_s, wr_s, drop_s;
   logic [EW-1:0]        head_nxt_s;
   logic [DATA_BITS-1:0] rd_data_r;
   logic [2:0]           rd_err_r;
   logic                 rda_r, overrun_r;

   assign tick_s = (state_r != IDLE) && (tcnt_r == {DIV_W{1'b0}});
   assign at9_s  = tick_s && (tick_idx_r == 4'd9);
   assign end_s  = tick_s && (tick_idx_r == 4'd15);
   // Third vote is the live synchronised sample at tick 9.
   assign maj_s  = (samp_r[0] & samp_r[1]) | (samp_r[0] & rxs_r) | (samp_r[1] & rxs_r);

`ifdef SPART_RX_BREAK_EN
   assign brk_s   = (shift_r == {DATA_BITS{1'b0}}) && !(par_en_r && par_bit_r) && !maj_s;
   assign entry_s = brk_s ? {1'b1, 1'b1, 1'b0, {DATA_BITS{1'b0}}}
                          : {1'b0, ~maj_s, par_err_r, shift_r};
`else
   assign entry_s = {1'b0, ~maj_s, par_err_r, shift_r};
`endif

   // Receive FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Receive FSM next state and datapath strobes.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      shift_en_s  = 1'b0;
      par_smp_s   = 1'b0;
      push_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if ((divisor != {DIV_W{1'b0}}) && !rxs_r && rxs_prev_r) begin
               state_nxt_s = START;
               start_s     = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (at9_s && maj_s) begin
               state_nxt_s = IDLE;
            end else if (end_s) begin
               state_nxt_s = DATA;
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            shift_en_s = at9_s;
            if (end_s && (bit_cnt_r == LAST_BIT)) begin
               state_nxt_s = par_en_r ? PARITY : STOP;
            end else begin
               state_nxt_s = DATA;
            end
         end
         PARITY: begin
            par_smp_s = at9_s;
            if (end_s) begin
               state_nxt_s = STOP;
            end else begin
               state_nxt_s = PARITY;
            end
         end
         STOP: begin
            // Leave at the stop decision rather than tick 15 for early resync.
            if (at9_s) begin
               push_s = 1'b1;
`ifdef SPART_RX_BREAK_EN
               state_nxt_s = brk_s ? BRK_WAIT : IDLE;
`else
               state_nxt_s = IDLE;
`endif
            end else begin
               state_nxt_s = STOP;
            end
         end
`ifdef SPART_RX_BREAK_EN
         BRK_WAIT: begin
            if (tick_s && hi_seen_r && rxs_r) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = BRK_WAIT;
            end
         end
`endif
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Synchroniser, tick generator, bit sampling, shift register and push request.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r      <= 1'b1;
         rxs_r        <= 1'b1;
         rxs_prev_r   <= 1'b1;
         tcnt_r       <= {DIV_W{1'b0}};
         tick_idx_r   <= 4'd0;
         samp_r       <= 2'b00;
         bit_cnt_r    <= 4'd0;
         shift_r      <= {DATA_BITS{1'b0}};
         par_en_r     <= 1'b0;
         par_odd_r    <= 1'b0;
         par_err_r    <= 1'b0;
         push_req_r   <= 1'b0;
         push_entry_r <= {EW{1'b0}};
`ifdef SPART_RX_BREAK_EN
         par_bit_r    <= 1'b0;
         hi_seen_r    <= 1'b0;
`endif
      end else begin
         sync1_r    <= rxd;
         rxs_r      <= sync1_r;
         rxs_prev_r <= rxs_r;
         // Reload on start detection so tick phase aligns to the start edge.
         if (start_s || (tcnt_r == {DIV_W{1'b0}})) begin
            tcnt_r <= divisor - DIV_ONE;
         end else begin
            tcnt_r <= tcnt_r - DIV_ONE;
         end
         if (start_s) begin
            tick_idx_r <= 4'd0;
         end else if (tick_s) begin
            tick_idx_r <= tick_idx_r + 4'd1;
         end
         if (tick_s && (tick_idx_r == 4'd7)) begin
            samp_r[0] <= rxs_r;
         end
         if (tick_s && (tick_idx_r == 4'd8)) begin
            samp_r[1] <= rxs_r;
         end
         if (start_s) begin
            bit_cnt_r <= 4'd0;
            par_en_r  <= (par_mode == 2'b01) || (par_mode == 2'b10);
            par_odd_r <= (par_mode == 2'b10);
            par_err_r <= 1'b0;
`ifdef SPART_RX_BREAK_EN
            par_bit_r <= 1'b0;
`endif
         end else if (shift_en_s) begin
            shift_r   <= {maj_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
         end else if (par_smp_s) begin
            par_err_r <= par_err_f(shift_r, maj_s, par_odd_r);
`ifdef SPART_RX_BREAK_EN
            par_bit_r <= maj_s;
`endif
         end
         push_req_r <= push_s;
         if (push_s) begin
            push_entry_r <= entry_s;
         end
`ifdef SPART_RX_BREAK_EN
         // Set at a tick with the line high; any low cycle before the next tick clears it.
         if (push_s) begin
            hi_seen_r <= 1'b0;
         end else if (tick_s) begin
            hi_seen_r <= rxs_r;
         end else if (!rxs_r) begin
            hi_seen_r <= 1'b0;
         end
`endif
      end
   end

   assign pop_s        = rd_en && (fcnt_r != {(AW+1){1'b0}});
   assign full_s       = (fcnt_r == CNT_FULL);
   assign wr_s         = push_req_r && (!full_s || pop_s);
   assign drop_s       = push_req_r && full_s && !pop_s;
   assign rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;

   // FIFO occupancy after this cycle's push/pop.
   always_comb begin
      fcnt_nxt_s = fcnt_r;
      case ({wr_s, pop_s})
         2'b10:   fcnt_nxt_s = fcnt_r + {{AW{1'b0}}, 1'b1};
         2'b01:   fcnt_nxt_s = fcnt_r - {{AW{1'b0}}, 1'b1};
         default: fcnt_nxt_s = fcnt_r;
      endcase
   end

   // Next show-ahead head; bypass the entry being written when it becomes the head.
   always_comb begin
      head_nxt_s = {EW{1'b0}};
      if (fcnt_nxt_s == {(AW+1){1'b0}}) begin
         head_nxt_s = {EW{1'b0}};
      end else if (wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_nxt_s = push_entry_r;
      end else begin
         head_nxt_s = mem[rd_ptr_nxt_s];
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem[wr_ptr_r] <= push_entry_r;
      end
   end

   // FIFO pointers, count, overrun and registered head outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         fcnt_r    <= {(AW+1){1'b0}};
         overrun_r <= 1'b0;
         rd_data_r <= {DATA_BITS{1'b0}};
         rd_err_r  <= 3'b000;
         rda_r     <= 1'b0;
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         fcnt_r   <= fcnt_nxt_s;
         // A new drop wins over a coincident clear.
         if (drop_s) begin
            overrun_r <= 1'b1;
         end else if (ovr_clr) begin
            overrun_r <= 1'b0;
         end
         rd_data_r <= head_nxt_s[DATA_BITS-1:0];
         rd_err_r  <= head_nxt_s[EW-1:DATA_BITS];
         rda_r     <= (fcnt_nxt_s != {(AW+1){1'b0}});
      end
   end

   assign rd_data  = rd_data_r;
   assign rd_err   = rd_err_r;
   assign rda      = rda_r;
   assign fifo_cnt = fcnt_r;
   assign overrun  = overrun_r;

endmodule

// File: doc/spart_rx_param.md
Name: spart_rx_param

Overview:
- Parametrised next-generation SPART receiver: 16x oversampled serial input, 3-sample majority vote, configurable data width, runtime parity mode, per-entry error flags, receive FIFO with show-ahead read.
- Sits between the rxd pin and the SPART bus interface. The bus side pops entries with rd_en; the divisor buffer supplies clocks-per-oversample-tick.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line.
- FIFO_DEPTH, 4, receive FIFO entries, power of two, 2..64.
- DIV_W, 16, width of divisor input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input, idle high.
- divisor  in  DIV_W  clocks per oversample tick; 0 = receiver held in IDLE.
- par_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- rd_en  in  1  pop FIFO head this cycle.
- ovr_clr  in  1  clear sticky overrun flag.
- rd_data  out  DATA_BITS  FIFO head data (show-ahead); 0 when empty.
- rd_err  out  3  FIFO head flags {break, frame, parity}; 0 when empty.
- rda  out  1  FIFO non-empty.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  entries held.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, FIFO empty, 2-FF synchroniser preset to 1, tick counter 0. Reset mid-frame aborts the frame; nothing is pushed.
- rxd passes through a 2-FF synchroniser. All decisions use the synchronised value rxs.
- Tick generator:
  - Down-counter reloads divisor-1; a tick fires when it reaches 0.
  - The counter is forced to reload on start detection, so phase aligns to the start edge.
  - A divisor change takes effect at the next reload.
- Bit timing:
  - Each bit spans ticks 0..15.
  - Samples are taken at ticks 7, 8 and 9; bit value = majority of the three, decided at tick 9.
  - The bit ends after tick 15.
- FSM:
  - IDLE: stay while divisor == 0. Move to START when rxs is 0 and was 1 on the previous cycle. Latch par_mode and clear the bit count.
  - START: majority 1 at tick 9 = false start, return to IDLE with no push. Otherwise go to DATA after tick 15.
  - DATA: shift majority into a shift register LSB-first. After DATA_BITS bits, go to PARITY if the latched mode is even or odd, else to STOP.
  - PARITY: parity error if (XOR of data bits) XOR (received bit) is not 0 for even, or not 1 for odd.
  - STOP: majority taken at tick 9; frame error if it is 0. The push request is issued in the same cycle as the tick-9 decision, and the FSM returns to IDLE immediately (no wait for tick 15, giving early resync).
- FIFO:
  - The entry {break, frame, parity, data} is written on the clock edge after the push request.
  - rda and fifo_cnt update on the next edge (2 clk after the stop-sample tick).
  - Pop with rd_en and rda: head advances next edge. rd_en while empty is ignored, state unchanged.
  - Push and pop together when full: both succeed, count unchanged, no overrun.
  - Push when full without pop: frame dropped, overrun set to 1 next edge.
  - ovr_clr clears overrun. If ovr_clr coincides with a new overrun, overrun stays 1.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: SPART_RX_BREAK_EN.
- Defined: a frame with all data bits 0, parity bit 0 (if enabled) and stop 0 is pushed with break=1, frame=1, data=0. The FSM then enters BRK_WAIT and stays until rxs is 1 for a full tick, then goes to IDLE.
- Not defined: rd_err[2] is tied 0 and there is no BRK_WAIT state. The same frame is pushed with frame=1 only, and the FSM returns to IDLE. IDLE needs a 1-to-0 edge, so a held-low line never retriggers.

Test Plan:
- Frame 0xA5, divisor=4 (64 clk/bit), par_mode=00, good stop -> rda=1 about 2 clk after stop sample; rd_data=0xA5, rd_err=000; rd_en pop -> rda=0, rd_data=0.
- Frame 0xE7, par_mode=01, parity bit 1 (wrong) -> rd_data=0xE7, rd_err=001. Same frame with parity bit 0 -> rd_err=000.
- Frame 0x24 with stop bit 0 -> rd_err=010, data 0x24. A 3-tick low glitch on idle line -> false start, fifo_cnt unchanged.
- FIFO_DEPTH=4: send 5 frames 0x01..0x05 with no reads -> fifo_cnt=4, overrun=1; pops return 0x01..0x04. ovr_clr -> overrun=0.
- Full FIFO, rd_en asserted in the push cycle of frame 0x06 -> overrun stays 0, fifo_cnt stays 4, last entry 0x06.
- Line held low 20 bit times: with SPART_RX_BREAK_EN -> one entry rd_err=110, data 0, no further entries until line high; without -> one entry rd_err=010. Reset asserted mid-DATA -> fifo_cnt=0, next clean 0x5A frame received correctly.
